// File: rtl/rom_scan_reader.sv
// rom_scan_reader
//   Drives the 8x8 model ROM (addr/rd_en/cs -> data_out) to read a run of
//   consecutive words starting at a base address. The address wraps modulo
//   2**ADDR_W. Each word is offered on a valid/ready stream, and the bench
//   or consumer sees a running checksum of the accepted words.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      scan request, honoured only while idle
//   base_addr  first ROM address, captured with start
//   count      number of words (0..2**ADDR_W), captured with start
//   rom_addr   registered ROM address
//   rom_rd_en  registered ROM read enable
//   rom_cs     registered ROM chip select
//   rom_data   ROM data_out (combinational from rom_addr)
//   out_data   captured word
//   out_valid  out_data valid
//   out_ready  consumer ready; transfer on out_valid && out_ready
//   out_last   marks the final word of the scan
//   busy       high whenever a scan is in progress (any non-idle state)
//   done       one-cycle pulse when the scan completes
//   checksum   sum of accepted words, held until the next start
module rom_scan_reader #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [ADDR_W:0]          count,
  output logic [ADDR_W-1:0]        rom_addr,
  output logic                     rom_rd_en,
  output logic                     rom_cs,
  input  logic [DATA_W-1:0]        rom_data,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_W+ADDR_W-1:0] checksum
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W+1)'(1);

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [ADDR_W-1:0]          r_cur;
  logic [ADDR_W:0]            r_rem;
  logic [DATA_W-1:0]          r_out_data;
  logic                       r_out_valid;
  logic                       r_rom_en;
  logic [DATA_W+ADDR_W-1:0]   r_sum;
  logic                       w_hs;
  logic                       w_last_word;

  assign w_hs        = (r_state == S_SEND) && out_ready;
  assign w_last_word = (r_rem == REM_ONE);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (count != '0) ? S_READ : S_DONE;
        end
      end
      S_READ: w_state_nxt = S_SEND;
      S_SEND: begin
        if (w_hs) begin
          w_state_nxt = w_last_word ? S_DONE : S_READ;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Address, ROM strobes, output word and checksum.
  // The ROM strobes are set on the edge that enters READ, so the ROM sees
  // a stable address for the whole READ cycle and the word is captured on
  // the edge that leaves it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cur       <= '0;
      r_rem       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_rom_en    <= 1'b0;
      r_sum       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sum <= '0;
            if (count != '0) begin
              r_cur    <= base_addr;
              r_rem    <= count;
              r_rom_en <= 1'b1;
            end
          end
        end
        S_READ: begin
          r_out_data  <= rom_data;
          r_out_valid <= 1'b1;
          r_rom_en    <= 1'b0;
        end
        S_SEND: begin
          if (w_hs) begin
            r_sum       <= r_sum + {{ADDR_W{1'b0}}, r_out_data};
            r_rem       <= r_rem - REM_ONE;
            r_cur       <= r_cur + ADDR_ONE;
            r_out_valid <= 1'b0;
            // Re-arm the ROM for the next word unless this was the last one.
            r_rom_en    <= !w_last_word;
          end
        end
        default: ;
      endcase
    end
  end

  assign rom_addr  = r_cur;
  assign rom_rd_en = r_rom_en;
  assign rom_cs    = r_rom_en;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_valid && w_last_word;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign checksum  = r_sum;

endmodule

// File: tb/tb_rom_scan_reader.sv
// Bench for rom_scan_reader: model ROM plus scenario tasks, each compared
// against expectations derived from the ROM contents and scan rules.
module tb_rom_scan_reader;

  localparam int AW = 3;
  localparam int DW = 8;
  localparam int SW = DW + AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   count = '0;
  logic [AW-1:0] rom_addr;
  logic          rom_rd_en;
  logic          rom_cs;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic          busy;
  logic          done;
  logic [SW-1:0] checksum;

  logic [DW-1:0] rom [0:7] = '{8'd99, 8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66, 8'd77};

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Model ROM: drives data only while selected and read-enabled.
  assign rom_data = (rom_cs && rom_rd_en) ? rom[rom_addr] : '0;

  rom_scan_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .rom_addr  (rom_addr),
    .rom_rd_en (rom_rd_en),
    .rom_cs    (rom_cs),
    .rom_data  (rom_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs one scan and checks it cycle by cycle. stall < 0 picks a random
  // 0..3 cycle stall per word; otherwise the first word stalls 'stall'
  // cycles and the rest none. mid_start re-pulses start (base 5) while busy.
  task automatic run_scan(input int base, input int cnt, input int stall,
                          input bit mid_start, output logic [SW-1:0] sum_o);
    logic [SW-1:0] sum;
    logic [AW-1:0] a;
    logic [DW-1:0] w;
    logic          lst;
    int            k;
    sum = '0;
    @(negedge clk);
    start = 1'b1; base_addr = AW'(base); count = (AW+1)'(cnt); out_ready = 1'b0;
    tick;
    start = 1'b0;
    if (cnt == 0) begin
      n_vec++;
      if ({done, busy, out_valid, rom_cs, checksum} !== {1'b1, 1'b1, 1'b0, 1'b0, {SW{1'b0}}}) begin
        n_fail++;
        $display("FAIL empty_done: done/busy/valid/cs=%b%b%b%b sum=%0d, want 1100 sum=0",
                 done, busy, out_valid, rom_cs, checksum);
      end
    end else begin
      for (int i = 0; i < cnt; i++) begin
        a   = AW'((base + i) % 8);
        w   = rom[a];
        lst = (i == cnt - 1);
        n_vec++;
        if ({rom_cs, rom_rd_en, rom_addr, out_valid, done, busy} !== {1'b1, 1'b1, a, 1'b0, 1'b0, 1'b1}) begin
          n_fail++;
          $display("FAIL read_phase w%0d: cs/rd/addr/valid/done/busy=%b%b/%0d/%b%b%b, want 11/%0d/001",
                   i, rom_cs, rom_rd_en, rom_addr, out_valid, done, busy, a);
        end
        if (mid_start && i == 1) begin
          start = 1'b1; base_addr = 3'd5; count = 4'd3;
        end
        tick;
        start = 1'b0;
        k = (stall < 0) ? int'($urandom_range(0, 3)) : ((i == 0) ? stall : 0);
        for (int j = 0; j <= k; j++) begin
          n_vec++;
          if ({out_valid, out_data, out_last, rom_cs, rom_rd_en, checksum, busy, done} !==
              {1'b1, w, lst, 1'b0, 1'b0, sum, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL send_phase w%0d c%0d: valid=%b data=%0d last=%b cs/rd=%b%b sum=%0d busy/done=%b%b, want 1 %0d %b 00 %0d 10",
                     i, j, out_valid, out_data, out_last, rom_cs, rom_rd_en, checksum, busy, done, w, lst, sum);
          end
          out_ready = (j == k);
          tick;
        end
        out_ready = 1'b0;
        sum = sum + SW'(w);
      end
      n_vec++;
      if ({done, busy, out_valid, out_last, checksum} !== {1'b1, 1'b1, 1'b0, 1'b0, sum}) begin
        n_fail++;
        $display("FAIL done_pulse: done/busy/valid/last=%b%b%b%b sum=%0d, want 1100 sum=%0d",
                 done, busy, out_valid, out_last, checksum, sum);
      end
    end
    tick;
    n_vec++;
    if ({done, busy, out_valid, rom_cs, rom_rd_en, checksum} !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, sum}) begin
      n_fail++;
      $display("FAIL back_idle: done/busy/valid/cs/rd=%b%b%b%b%b sum=%0d, want 00000 sum=%0d",
               done, busy, out_valid, rom_cs, rom_rd_en, checksum, sum);
    end
    sum_o = sum;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b1; count = 4'd4; out_ready = 1'b1;
    tick;
    tick;
    n_vec++;
    if ({rom_addr, rom_rd_en, rom_cs, out_data, out_valid, out_last, busy, done, checksum} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: addr=%0d rd=%b cs=%b data=%0d valid=%b last=%b busy=%b done=%b sum=%0d, want all 0",
               rom_addr, rom_rd_en, rom_cs, out_data, out_valid, out_last, busy, done, checksum);
    end
    rst_n = 1'b1; start = 1'b0; out_ready = 1'b0;
    tick;
    n_vec++;
    if ({busy, done, out_valid, rom_cs} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_release: busy/done/valid/cs=%b%b%b%b, want 0000", busy, done, out_valid, rom_cs);
    end
  endtask

  task automatic check_sum(input string name, input logic [SW-1:0] got, input logic [SW-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: checksum=%0d, want %0d", name, got, want);
    end
  endtask

  task automatic test_full_scan;
    logic [SW-1:0] s;
    run_scan(0, 8, 0, 1'b0, s);
    check_sum("full_scan_sum", s, 11'd407);
  endtask

  task automatic test_wrap;
    logic [SW-1:0] s;
    run_scan(6, 4, 0, 1'b0, s);
    check_sum("wrap_sum", s, 11'd253);
  endtask

  task automatic test_stall;
    logic [SW-1:0] s;
    run_scan(2, 2, 3, 1'b0, s);
    check_sum("stall_sum", s, 11'd55);
  endtask

  task automatic test_empty;
    logic [SW-1:0] s;
    run_scan(1, 0, 0, 1'b0, s);
    check_sum("empty_sum", s, 11'd0);
  endtask

  task automatic test_reset_mid_scan;
    logic [SW-1:0] s;
    @(negedge clk);
    start = 1'b1; base_addr = 3'd0; count = 4'd8; out_ready = 1'b1;
    tick;
    start = 1'b0;
    repeat (5) tick;
    n_vec++;
    if ({out_valid, out_data} !== {1'b1, 8'd22}) begin
      n_fail++;
      $display("FAIL abort_word3: valid=%b data=%0d, want 1 22", out_valid, out_data);
    end
    rst_n = 1'b0; out_ready = 1'b0;
    tick;
    n_vec++;
    if ({rom_addr, rom_rd_en, rom_cs, out_data, out_valid, out_last, busy, done, checksum} !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: addr=%0d rd=%b cs=%b data=%0d valid=%b last=%b busy=%b done=%b sum=%0d, want all 0",
               rom_addr, rom_rd_en, rom_cs, out_data, out_valid, out_last, busy, done, checksum);
    end
    rst_n = 1'b1;
    tick;
    n_vec++;
    if ({done, busy, out_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_no_done: done/busy/valid=%b%b%b, want 000", done, busy, out_valid);
    end
    run_scan(6, 4, 0, 1'b0, s);
    check_sum("after_abort_sum", s, 11'd253);
  endtask

  task automatic test_start_ignored;
    logic [SW-1:0] s;
    run_scan(0, 8, 0, 1'b1, s);
    check_sum("start_ignored_sum", s, 11'd407);
  endtask

  task automatic test_random;
    logic [SW-1:0] s;
    logic [SW-1:0] want;
    int b;
    int c;
    for (int n = 0; n < 25; n++) begin
      b = int'($urandom_range(0, 7));
      c = int'($urandom_range(0, 8));
      want = '0;
      for (int i = 0; i < c; i++) want = want + SW'(rom[(b + i) % 8]);
      run_scan(b, c, -1, 1'b0, s);
      check_sum("random_sum", s, want);
    end
  endtask

  initial begin
    test_reset;
    test_full_scan;
    test_wrap;
    test_stall;
    test_empty;
    test_reset_mid_scan;
    test_start_ignored;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
